// File: rtl/vr_stream_sink_checker.sv
// Stream terminator for a valid/ready byte stream: drives pseudo-random backpressure,
// checks accepted data against an incrementing sequence and flags protocol violations.
module vr_stream_sink_checker #(
    parameter int unsigned   DW           = 8,
    parameter int unsigned   CW           = 16,
    parameter logic [DW-1:0] START_VAL    = '0,
    parameter logic [7:0]    LFSR_SEED    = 8'hA5,
    parameter int unsigned   STALL_THRESH = 4,
    parameter bit            STOP_ON_ERR  = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic          i_restart,
    input  logic          dn_val,
    input  logic [DW-1:0] dn_bus,
    output logic          dn_rdy,
    output logic [DW-1:0] o_expected,
    output logic [CW-1:0] o_beat_cnt,
    output logic [CW-1:0] o_err_cnt,
    output logic [2:0]    o_err_flags,
    output logic          o_halted
);

    // 5 bits so that a threshold of 16 (always stall) is representable
    localparam logic [4:0] THRESH = 5'(STALL_THRESH);

    typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

    state_t        r_state;
    logic [7:0]    r_lfsr;
    logic          r_rdy;
    logic [DW-1:0] r_expected;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] r_err_cnt;
    logic [2:0]    r_flags;
    logic          r_halted;
    // One-cycle history of the upstream side for the protocol check
    logic          r_prev_val;
    logic          r_prev_rdy;
    logic [DW-1:0] r_prev_bus;

    state_t        w_state_next;
    logic [7:0]    w_lfsr_shift;
    logic [7:0]    w_lfsr_next;
    logic          w_rdy_next;
    logic          w_run;
    logic          w_accept;
    logic          w_mismatch;
    logic          w_prot_drop;
    logic          w_prot_chg;
    logic          w_err_any;

    // Error detection for the current cycle
    always_comb begin
        w_run       = (r_state == StRun);
        w_accept    = w_run & dn_val & r_rdy;
        w_mismatch  = w_accept & (dn_bus != r_expected);
        w_prot_drop = w_run & r_prev_val & ~r_prev_rdy & ~dn_val;
        w_prot_chg  = w_run & r_prev_val & ~r_prev_rdy & dn_val & (dn_bus != r_prev_bus);
        w_err_any   = w_mismatch | w_prot_drop | w_prot_chg;
    end

    // Next state, next LFSR value and the ready decision derived from them
    always_comb begin
        // Fibonacci LFSR for x^8+x^6+x^5+x^4+1
        w_lfsr_shift = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        w_state_next = r_state;
        w_lfsr_next  = w_run ? w_lfsr_shift : r_lfsr;
        if (i_restart) begin
            w_state_next = i_enable ? StRun : StIdle;
            w_lfsr_next  = LFSR_SEED;
        end else begin
            unique case (r_state)
                StIdle: if (i_enable) w_state_next = StRun;
                StRun: begin
                    if (STOP_ON_ERR && w_err_any) w_state_next = StHalt;
                    else if (!i_enable)           w_state_next = StIdle;
                end
                StHalt: w_state_next = StHalt;
                default: w_state_next = StIdle;
            endcase
        end
        w_rdy_next = (w_state_next == StRun) & ({1'b0, w_lfsr_next[3:0]} >= THRESH);
    end

    // All state: FSM, backpressure, reference value, counters, flags and history
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_lfsr     <= LFSR_SEED;
            r_rdy      <= 1'b0;
            r_expected <= START_VAL;
            r_beat_cnt <= '0;
            r_err_cnt  <= '0;
            r_flags    <= '0;
            r_halted   <= 1'b0;
            r_prev_val <= 1'b0;
            r_prev_rdy <= 1'b0;
            r_prev_bus <= '0;
        end else if (i_restart) begin
            // Any beat presented on the restart edge is discarded with the old run
            r_state    <= w_state_next;
            r_lfsr     <= w_lfsr_next;
            r_rdy      <= w_rdy_next;
            r_expected <= START_VAL;
            r_beat_cnt <= '0;
            r_err_cnt  <= '0;
            r_flags    <= '0;
            r_halted   <= 1'b0;
            r_prev_val <= 1'b0;
            r_prev_rdy <= 1'b0;
            r_prev_bus <= '0;
        end else begin
            r_state  <= w_state_next;
            r_lfsr   <= w_lfsr_next;
            r_rdy    <= w_rdy_next;
            r_halted <= (w_state_next == StHalt);
            if (w_accept) begin
                // Resync on the received value so one bad beat gives one mismatch
                r_expected <= dn_bus + DW'(1);
                if (r_beat_cnt != '1) r_beat_cnt <= r_beat_cnt + CW'(1);
            end
            if (w_err_any && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CW'(1);
            r_flags <= r_flags | {w_prot_chg, w_prot_drop, w_mismatch};
            // History only carries across consecutive RUN cycles, so entry to RUN starts clean
            if (w_run && (w_state_next == StRun)) begin
                r_prev_val <= dn_val;
                r_prev_rdy <= r_rdy;
                r_prev_bus <= dn_bus;
            end else begin
                r_prev_val <= 1'b0;
                r_prev_rdy <= 1'b0;
                r_prev_bus <= '0;
            end
        end
    end

    assign dn_rdy      = r_rdy;
    assign o_expected  = r_expected;
    assign o_beat_cnt  = r_beat_cnt;
    assign o_err_cnt   = r_err_cnt;
    assign o_err_flags = r_flags;
    assign o_halted    = r_halted;

endmodule

// File: tb/tb_vr_stream_sink_checker.sv
// Bench for vr_stream_sink_checker: three instances cover never-stall / stop-on-error,
// pseudo-random stall and always-stall configurations.
module tb_vr_stream_sink_checker;

    localparam int N = 3;
    localparam int F_RDY = 0, F_EXP = 1, F_BEAT = 2, F_ERR = 3, F_FLG = 4, F_HLT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        en   [N];
    logic        rs   [N];
    logic        val  [N];
    logic [7:0]  bus  [N];
    logic        rdy_o[N];
    logic [7:0]  exp_o[N];
    logic [15:0] beat_o[N];
    logic [15:0] err_o[N];
    logic [2:0]  flg_o[N];
    logic        hlt_o[N];

    always #5 clk = ~clk;

    // Never stalls, halts on first error
    vr_stream_sink_checker #(
        .DW(8), .CW(16), .START_VAL(8'h00), .LFSR_SEED(8'hA5), .STALL_THRESH(0), .STOP_ON_ERR(1'b1)
    ) u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_enable(en[0]), .i_restart(rs[0]),
        .dn_val(val[0]), .dn_bus(bus[0]), .dn_rdy(rdy_o[0]), .o_expected(exp_o[0]),
        .o_beat_cnt(beat_o[0]), .o_err_cnt(err_o[0]), .o_err_flags(flg_o[0]), .o_halted(hlt_o[0])
    );

    // Random stalls, sequence starts just below the wrap point
    vr_stream_sink_checker #(
        .DW(8), .CW(16), .START_VAL(8'hFD), .LFSR_SEED(8'hA5), .STALL_THRESH(8), .STOP_ON_ERR(1'b0)
    ) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_enable(en[1]), .i_restart(rs[1]),
        .dn_val(val[1]), .dn_bus(bus[1]), .dn_rdy(rdy_o[1]), .o_expected(exp_o[1]),
        .o_beat_cnt(beat_o[1]), .o_err_cnt(err_o[1]), .o_err_flags(flg_o[1]), .o_halted(hlt_o[1])
    );

    // Always stalls, keeps running on errors
    vr_stream_sink_checker #(
        .DW(8), .CW(16), .START_VAL(8'h00), .LFSR_SEED(8'hA5), .STALL_THRESH(16), .STOP_ON_ERR(1'b0)
    ) u_dut2 (
        .i_clk(clk), .i_reset(rst), .i_enable(en[2]), .i_restart(rs[2]),
        .dn_val(val[2]), .dn_bus(bus[2]), .dn_rdy(rdy_o[2]), .o_expected(exp_o[2]),
        .o_beat_cnt(beat_o[2]), .o_err_cnt(err_o[2]), .o_err_flags(flg_o[2]), .o_halted(hlt_o[2])
    );

    typedef struct {
        string       name;
        int          id;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        int          d;
        logic [7:0]  exp;
        logic [15:0] cnt;
    } beat_t;

    chk_t  chk_q[$];
    beat_t beat_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    function automatic logic [31:0] probe(int id);
        int d = id / 8;
        case (id % 8)
            F_RDY:   return {31'b0, rdy_o[d]};
            F_EXP:   return {24'b0, exp_o[d]};
            F_BEAT:  return {16'b0, beat_o[d]};
            F_ERR:   return {16'b0, err_o[d]};
            F_FLG:   return {29'b0, flg_o[d]};
            default: return {31'b0, hlt_o[d]};
        endcase
    endfunction

    // Monitor: pops queued expectations and compares against the DUT away from the active edge
    always @(negedge clk) begin
        chk_t  c;
        beat_t b;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_vec++;
            if (probe(c.id) !== c.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%0h, want 0x%0h", c.name, probe(c.id), c.exp);
            end
        end
        if (!rst) begin
            for (int d = 0; d < N; d++) begin
                if (val[d] && rdy_o[d] && beat_q.size() > 0 && beat_q[0].d == d) begin
                    b = beat_q.pop_front();
                    n_vec++;
                    if (exp_o[d] !== b.exp || beat_o[d] !== b.cnt) begin
                        n_err++;
                        $display("FAIL beat dut%0d: expected/count got 0x%0h/%0d, want 0x%0h/%0d",
                                 d, exp_o[d], beat_o[d], b.exp, b.cnt);
                    end
                end
            end
        end
    end

    task automatic expect_val(string name, int d, int f, logic [31:0] v);
        chk_q.push_back('{name: $sformatf("dut%0d %s", d, name), id: d * 8 + f, exp: v});
    endtask

    task automatic expect_all(string tag, int d, logic r, logic [7:0] e, logic [15:0] bc,
                              logic [15:0] ec, logic [2:0] fl, logic h);
        expect_val({tag, " rdy"}, d, F_RDY, {31'b0, r});
        expect_val({tag, " expected"}, d, F_EXP, {24'b0, e});
        expect_val({tag, " beat_cnt"}, d, F_BEAT, {16'b0, bc});
        expect_val({tag, " err_cnt"}, d, F_ERR, {16'b0, ec});
        expect_val({tag, " flags"}, d, F_FLG, {29'b0, fl});
        expect_val({tag, " halted"}, d, F_HLT, {31'b0, h});
    endtask

    // Let the monitor compare, then return just after the next active edge
    task automatic checkpoint();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat obeying the protocol; hold until accepted or the budget runs out
    task automatic send(int d, logic [7:0] v, logic [7:0] e_exp, logic [15:0] e_cnt);
        bit ok = 1'b0;
        val[d] = 1'b1;
        bus[d] = v;
        beat_q.push_back('{d: d, exp: e_exp, cnt: e_cnt});
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (rdy_o[d]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept timeout dut%0d: data 0x%0h not accepted in 64 cycles", d, v);
            beat_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < N; d++) begin
            en[d]  = 1'b0;
            rs[d]  = 1'b0;
            val[d] = 1'b0;
            bus[d] = 8'h00;
        end

        // Reset held for three edges
        step(3);
        expect_all("reset", 0, 1'b0, 8'h00, 16'd0, 16'd0, 3'b000, 1'b0);
        expect_all("reset", 1, 1'b0, 8'hFD, 16'd0, 16'd0, 3'b000, 1'b0);
        expect_all("reset", 2, 1'b0, 8'h00, 16'd0, 16'd0, 3'b000, 1'b0);
        checkpoint();

        // Back-to-back stream with no backpressure
        rst   = 1'b0;
        en[0] = 1'b1;
        step(1);
        expect_val("rdy after enable", 0, F_RDY, 32'd1);
        checkpoint();
        for (int i = 0; i < 16; i++) send(0, 8'(i), 8'(i), 16'(i));
        val[0] = 1'b0;
        expect_all("stream16", 0, 1'b1, 8'h10, 16'd16, 16'd0, 3'b000, 1'b0);
        checkpoint();

        // Restart into RUN, then a data mismatch halts the checker
        rs[0] = 1'b1;
        step(1);
        rs[0] = 1'b0;
        expect_all("restart", 0, 1'b1, 8'h00, 16'd0, 16'd0, 3'b000, 1'b0);
        checkpoint();
        send(0, 8'h00, 8'h00, 16'd0);
        send(0, 8'h01, 8'h01, 16'd1);
        send(0, 8'h05, 8'h02, 16'd2);
        val[0] = 1'b0;
        expect_all("mismatch", 0, 1'b0, 8'h06, 16'd3, 16'd1, 3'b001, 1'b1);
        checkpoint();
        expect_val("halt holds rdy low", 0, F_RDY, 32'd0);
        checkpoint();

        // Random stalls across the 0xFF -> 0x00 wrap
        en[1] = 1'b1;
        for (int i = 0; i < 6; i++) send(1, 8'(8'hFD + i), 8'(8'hFD + i), 16'(i));
        val[1] = 1'b0;
        expect_val("wrap expected", 1, F_EXP, 32'h03);
        expect_val("wrap beat_cnt", 1, F_BEAT, 32'd6);
        expect_val("wrap err_cnt", 1, F_ERR, 32'd0);
        expect_val("wrap flags", 1, F_FLG, 32'd0);
        expect_val("wrap halted", 1, F_HLT, 32'd0);
        checkpoint();

        // Protocol violations under permanent stall: data change, then valid drop
        en[2] = 1'b1;
        step(1);
        val[2] = 1'b1;
        bus[2] = 8'h22;
        step(2);
        bus[2] = 8'h23;
        step(2);
        val[2] = 1'b0;
        step(2);
        expect_all("protocol", 2, 1'b0, 8'h00, 16'd0, 16'd2, 3'b110, 1'b0);
        checkpoint();
        rs[2] = 1'b1;
        step(1);
        rs[2] = 1'b0;
        expect_all("protocol restart", 2, 1'b0, 8'h00, 16'd0, 16'd0, 3'b000, 1'b0);
        checkpoint();

        // Reset lands on an edge with a handshake in flight
        rs[0] = 1'b1;
        step(1);
        rs[0] = 1'b0;
        send(0, 8'h00, 8'h00, 16'd0);
        send(0, 8'h01, 8'h01, 16'd1);
        val[0] = 1'b1;
        bus[0] = 8'h02;
        rst    = 1'b1;
        step(1);
        rst    = 1'b0;
        val[0] = 1'b0;
        expect_all("reset mid-run", 0, 1'b0, 8'h00, 16'd0, 16'd0, 3'b000, 1'b0);
        expect_val("reset mid-run expected", 1, F_EXP, 32'hFD);
        checkpoint();

        n_vec++;
        if (beat_q.size() != 0) begin
            n_err++;
            $display("FAIL beat queue drain: %0d beats left, want 0", beat_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
